// File: rtl/axi_pack_rd_arbiter.sv
// Round-robin AR arbiter with a registered output stage; R beats are steered back to the
// owner of the oldest outstanding burst through an in-order grant FIFO.
module axi_pack_rd_arbiter #(
    parameter int unsigned NumReq         = 2,
    parameter int unsigned ArPayWidth     = 64,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NumReq-1:0]                 ar_valid_i,
    output logic [NumReq-1:0]                 ar_ready_o,
    input  logic [NumReq*ArPayWidth-1:0]      ar_pay_i,
    output logic                              mst_ar_valid_o,
    input  logic                              mst_ar_ready_i,
    output logic [ArPayWidth-1:0]             mst_ar_pay_o,
    input  logic                              mst_r_valid_i,
    output logic                              mst_r_ready_o,
    input  logic [DataWidth-1:0]              mst_r_data_i,
    input  logic                              mst_r_last_i,
    output logic [NumReq-1:0]                 r_valid_o,
    input  logic [NumReq-1:0]                 r_ready_i,
    output logic [DataWidth-1:0]              r_data_o,
    output logic                              r_last_o,
    output logic [$clog2(MaxOutstanding):0]   outstanding_o
);

    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding) + 1;
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

    logic [IdxW-1:0]       r_rr_ptr;
    logic                  r_stage_valid;
    logic [ArPayWidth-1:0] r_stage_pay;
    logic [IdxW-1:0]       r_fifo [MaxOutstanding];
    logic [PtrW-1:0]       r_wr_ptr;
    logic [PtrW-1:0]       r_rd_ptr;
    logic [CntW-1:0]       r_count;

    logic                  w_free;
    logic                  w_found;
    logic                  w_grant;
    logic [IdxW-1:0]       w_cand;
    logic [IdxW-1:0]       w_winner;
    logic [ArPayWidth-1:0] w_win_pay;
    logic [NumReq-1:0]     w_ar_ready;
    logic                  w_empty;
    logic [IdxW-1:0]       w_head;
    logic [NumReq-1:0]     w_r_valid;
    logic                  w_r_ready;
    logic                  w_push;
    logic                  w_pop;

    // Handshake rule on every channel: a beat moves on a clock edge where valid and ready
    // are both high; a valid, once raised, is expected to hold until it is accepted.

    assign w_free  = !r_stage_valid || mst_ar_ready_i;
    assign w_empty = (r_count == '0);
    assign w_head  = r_fifo[r_rd_ptr];

    // Scan starts just after the last winner so the most recent grantee has lowest priority.
    always_comb begin
        w_found   = 1'b0;
        w_winner  = '0;
        w_win_pay = '0;
        w_cand    = '0;
        for (int k = 1; k <= int'(NumReq); k++) begin
            w_cand = IdxW'((int'(r_rr_ptr) + k) % int'(NumReq));
            if (!w_found && ar_valid_i[w_cand]) begin
                w_found   = 1'b1;
                w_winner  = w_cand;
                w_win_pay = ar_pay_i[w_cand*ArPayWidth +: ArPayWidth];
            end
        end
    end

    // The count is registered, so a pop in a full cycle only frees a slot for the next cycle.
    assign w_grant = rst_ni && w_free && (r_count < MaxCnt) && w_found;
    assign w_push  = w_grant;

    always_comb begin
        w_ar_ready = '0;
        if (w_grant) begin
            w_ar_ready[w_winner] = 1'b1;
        end
    end

    always_comb begin
        w_r_valid = '0;
        w_r_ready = 1'b0;
        if (!w_empty) begin
            w_r_valid[w_head] = mst_r_valid_i;
            w_r_ready         = r_ready_i[w_head];
        end
    end

    assign w_pop = mst_r_valid_i && w_r_ready && mst_r_last_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr <= IdxW'(NumReq - 1);
        end else if (w_grant) begin
            r_rr_ptr <= w_winner;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stage_valid <= 1'b0;
            r_stage_pay   <= '0;
        end else if (w_grant) begin
            r_stage_valid <= 1'b1;
            r_stage_pay   <= w_win_pay;
        end else if (mst_ar_ready_i) begin
            r_stage_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(MaxOutstanding); i++) begin
                r_fifo[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_winner;
                r_wr_ptr         <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign ar_ready_o     = w_ar_ready;
    assign mst_ar_valid_o = r_stage_valid;
    assign mst_ar_pay_o   = r_stage_pay;
    assign r_valid_o      = w_r_valid;
    assign mst_r_ready_o  = w_r_ready;
    assign r_data_o       = mst_r_data_i;
    assign r_last_o       = mst_r_last_i;
    assign outstanding_o  = r_count;

    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni) !(w_pop && w_empty));
    a_ar_ready_1h:  assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(ar_ready_o));
    a_r_valid_1h:   assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(r_valid_o));

endmodule

// File: tb/tb_axi_pack_rd_arbiter.sv
// Randomized bench for axi_pack_rd_arbiter: a queue-based reference model predicts every
// cycle's outputs, and a separate monitor compares them against the DUT.
module tb_axi_pack_rd_arbiter;

    localparam int NR   = 2;
    localparam int PW   = 64;
    localparam int DW   = 32;
    localparam int MAXO = 8;
    localparam int CW   = $clog2(MAXO) + 1;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [NR-1:0]     ar_valid_i;
    logic [NR-1:0]     ar_ready_o;
    logic [NR*PW-1:0]  ar_pay_i;
    logic              mst_ar_valid_o;
    logic              mst_ar_ready_i;
    logic [PW-1:0]     mst_ar_pay_o;
    logic              mst_r_valid_i;
    logic              mst_r_ready_o;
    logic [DW-1:0]     mst_r_data_i;
    logic              mst_r_last_i;
    logic [NR-1:0]     r_valid_o;
    logic [NR-1:0]     r_ready_i;
    logic [DW-1:0]     r_data_o;
    logic              r_last_o;
    logic [CW-1:0]     outstanding_o;

    axi_pack_rd_arbiter #(
        .NumReq(NR), .ArPayWidth(PW), .DataWidth(DW), .MaxOutstanding(MAXO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_pay_i(ar_pay_i),
        .mst_ar_valid_o(mst_ar_valid_o), .mst_ar_ready_i(mst_ar_ready_i),
        .mst_ar_pay_o(mst_ar_pay_o),
        .mst_r_valid_i(mst_r_valid_i), .mst_r_ready_o(mst_r_ready_o),
        .mst_r_data_i(mst_r_data_i), .mst_r_last_i(mst_r_last_i),
        .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
        .r_data_o(r_data_o), .r_last_o(r_last_o),
        .outstanding_o(outstanding_o)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [NR-1:0] ar_ready;
        logic          ar_valid;
        logic [PW-1:0] ar_pay;
        logic [NR-1:0] r_valid;
        logic          r_ready;
        logic          beat;
        logic [DW-1:0] data;
        logic          last;
        logic [CW-1:0] outst;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model state ----------------
    int            m_last;       // index of the most recent grant
    logic          m_sv;         // downstream AR register occupied
    logic [PW-1:0] m_spay;
    int            owner_q[$];   // requester of each granted, uncompleted burst, oldest first
    logic [DW:0]   beat_q[$];    // {last,data} beats the memory still has to return
    logic          m_rhold;      // memory beat presented but not yet taken

    int p_arv, p_ardy, p_rv, p_rrdy;

    task automatic model_reset();
        m_last  = NR - 1;
        m_sv    = 1'b0;
        m_spay  = '0;
        m_rhold = 1'b0;
        owner_q.delete();
        beat_q.delete();
    endtask

    task automatic set_knobs(input int arv, input int ardy, input int rv, input int rrdy);
        p_arv = arv; p_ardy = ardy; p_rv = rv; p_rrdy = rrdy;
    endtask

    // ---------------- driver ----------------
    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            ar_valid_i[i]          = ($urandom_range(0, 99) < p_arv);
            ar_pay_i[i*PW +: PW]   = {$urandom(), $urandom()};
            r_ready_i[i]           = ($urandom_range(0, 99) < p_rrdy);
        end
        mst_ar_ready_i = ($urandom_range(0, 99) < p_ardy);
        if (m_rhold) mst_r_valid_i = 1'b1;
        else         mst_r_valid_i = (beat_q.size() > 0) && ($urandom_range(0, 99) < p_rv);
        if (mst_r_valid_i) {mst_r_last_i, mst_r_data_i} = beat_q[0];
        else               {mst_r_last_i, mst_r_data_i} = {1'($urandom()), 32'($urandom())};
    endtask

    // Predicts the outputs for the inputs just driven, then advances the model past the edge.
    task automatic model_step();
        exp_t e;
        int   win;
        int   len;
        e          = '0;
        e.ar_valid = m_sv;
        e.ar_pay   = m_spay;
        e.outst    = CW'(owner_q.size());
        win = -1;
        if ((!m_sv || mst_ar_ready_i) && owner_q.size() < MAXO) begin
            for (int k = 1; k <= NR; k++) begin
                if (win < 0 && ar_valid_i[(m_last + k) % NR]) win = (m_last + k) % NR;
            end
        end
        if (win >= 0) e.ar_ready[win] = 1'b1;
        if (owner_q.size() > 0) begin
            e.r_valid[owner_q[0]] = mst_r_valid_i;
            e.r_ready             = r_ready_i[owner_q[0]];
        end
        e.beat = mst_r_valid_i;
        if (mst_r_valid_i) {e.last, e.data} = beat_q[0];
        exp_q.push_back(e);

        if (mst_r_valid_i && e.r_ready) begin
            if (beat_q[0][DW]) void'(owner_q.pop_front());
            void'(beat_q.pop_front());
            m_rhold = 1'b0;
        end else begin
            m_rhold = mst_r_valid_i;
        end
        // Memory side: burst length comes from the two low payload bits (1..4 beats).
        if (m_sv && mst_ar_ready_i) begin
            len = int'(m_spay[1:0]) + 1;
            for (int b = 1; b <= len; b++) beat_q.push_back({(b == len), 32'($urandom())});
        end
        if (win >= 0) begin
            owner_q.push_back(win);
            m_sv   = 1'b1;
            m_spay = ar_pay_i[win*PW +: PW];
            m_last = win;
        end else if (mst_ar_ready_i) begin
            m_sv = 1'b0;
        end
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(posedge clk_i); #1;
            drive();
            @(negedge clk_i);
            model_step();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ar_ready"},     64'(ar_ready_o),     64'd0);
        chk({tag, "_mst_ar_valid"}, 64'(mst_ar_valid_o), 64'd0);
        chk({tag, "_mst_ar_pay"},   64'(mst_ar_pay_o),   64'd0);
        chk({tag, "_r_valid"},      64'(r_valid_o),      64'd0);
        chk({tag, "_mst_r_ready"},  64'(mst_r_ready_o),  64'd0);
        chk({tag, "_outstanding"},  64'(outstanding_o),  64'd0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i); #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ar_ready",     64'(ar_ready_o),     64'(e.ar_ready));
                chk("mst_ar_valid", 64'(mst_ar_valid_o), 64'(e.ar_valid));
                if (e.ar_valid) chk("mst_ar_pay", 64'(mst_ar_pay_o), 64'(e.ar_pay));
                chk("r_valid",      64'(r_valid_o),      64'(e.r_valid));
                chk("mst_r_ready",  64'(mst_r_ready_o),  64'(e.r_ready));
                chk("outstanding",  64'(outstanding_o),  64'(e.outst));
                if (e.beat) begin
                    chk("r_data", 64'(r_data_o), 64'(e.data));
                    chk("r_last", 64'(r_last_o), 64'(e.last));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_ni         = 1'b0;
        ar_valid_i     = '1;
        ar_pay_i       = '1;
        mst_ar_ready_i = 1'b1;
        mst_r_valid_i  = 1'b1;
        mst_r_data_i   = '0;
        mst_r_last_i   = 1'b0;
        r_ready_i      = '1;
        model_reset();
        set_knobs(0, 0, 0, 0);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_reset_outputs("por");
        @(posedge clk_i); #2;
        ar_valid_i    = '0;
        mst_r_valid_i = 1'b0;
        rst_ni        = 1'b1;

        // Mixed traffic, contention on both requesters, then fill to the outstanding limit.
        set_knobs(60, 70, 70, 70);   run_cycles(500);
        set_knobs(100, 100, 100, 100); run_cycles(40);
        set_knobs(100, 100, 0, 100);   run_cycles(30);
        set_knobs(100, 100, 100, 100); run_cycles(60);
        // Heavy backpressure on both AR and R sides.
        set_knobs(80, 10, 80, 20);   run_cycles(400);
        set_knobs(50, 50, 90, 40);   run_cycles(200);

        // Reset while bursts are outstanding and inputs are active.
        set_knobs(90, 100, 0, 100);  run_cycles(20);
        @(posedge clk_i); #3;
        rst_ni         = 1'b0;
        ar_valid_i     = '1;
        mst_ar_ready_i = 1'b0;
        mst_r_valid_i  = 1'b1;
        mst_r_data_i   = '0;
        mst_r_last_i   = 1'b0;
        r_ready_i      = '1;
        #1;
        check_reset_outputs("mid_rst");
        model_reset();
        repeat (2) @(posedge clk_i);
        #2;
        ar_valid_i    = '0;
        mst_r_valid_i = 1'b0;
        rst_ni        = 1'b1;

        // Both requesters valid right after release: requester 0 must win first.
        set_knobs(100, 100, 60, 60); run_cycles(10);
        set_knobs(70, 60, 70, 60);   run_cycles(300);

        @(negedge clk_i); #3;
        chk("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
